counter_sched: RTL and testbench

//   Round-robin scheduler that shares one WIDTH-bit up-counter among NREQ requesters.

---
 rtl/counter_sched_pkg.sv | 13 +
 rtl/sched_counter.sv | 28 ++
 rtl/counter_sched.sv | 118 +++++++++++
 tb/tb_counter_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default sizes.
package counter_sched_pkg;

  localparam int unsigned DefaultNreq  = 4;
  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sched_counter.sv
// WIDTH-bit up-counter shared by the scheduler.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (count -> 0)
//   clr    synchronous clear, wins over en
//   en     increment enable
//   count  current count value
module sched_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters. The winner owns
// the counter until it reaches the winner's delay, then receives a one-cycle done pulse.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   req       per-requester request level, held until done
//   delay_in  requester i delay at [i*WIDTH +: WIDTH], sampled only at arbitration
//   grant     one-hot current owner, 0 when idle
//   done      one-cycle completion pulse to the owner
//   busy      high while running or signalling done
//   cnt_q     current shared count
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DefaultNreq,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] delay_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt_q
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e     state_q;
  logic [IdxW-1:0]  owner_q;
  logic [IdxW-1:0]  rr_last_q;
  logic [WIDTH-1:0] target_q;

  logic [IdxW-1:0]  cand;
  logic [IdxW-1:0]  win_idx;
  logic             win_found;
  logic             req_own;
  logic             at_target;
  logic             abort;
  logic             cnt_clr;
  logic             cnt_en;

  // Search starts just above the last winner, so the last winner has lowest priority.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(rr_last_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_own   = req[owner_q];
  assign at_target = (cnt_q == target_q);
  assign abort     = (state_q == StRun) && !req_own;
  assign cnt_clr   = ((state_q == StIdle) && win_found) || abort;
  // Stop incrementing at the target so the count holds and can never wrap.
  assign cnt_en    = (state_q == StRun) && req_own && !at_target;
  assign busy      = (state_q != StIdle);

  sched_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      rr_last_q <= IdxW'(NREQ - 1);
      target_q  <= '0;
      grant     <= '0;
      done      <= '0;
    end else begin
      done <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            owner_q        <= win_idx;
            rr_last_q      <= win_idx;
            target_q       <= delay_in[win_idx*WIDTH +: WIDTH];
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            state_q        <= StRun;
          end
        end
        StRun: begin
          if (!req_own) begin
            grant   <= '0;
            state_q <= StIdle;
          end else if (at_target) begin
            grant         <= '0;
            done[owner_q] <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          grant   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_counter_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] delay_in = '0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      cnt_q;

  counter_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .delay_in(delay_in),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cnt_q   (cnt_q)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the counter, how long it has held it, its target.
  int              m_own;
  int              m_last;
  int              m_tgt;
  int              m_cnt;
  logic [NREQ-1:0] m_done;
  logic            m_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_last = NREQ - 1;
    m_tgt  = 0;
    m_cnt  = 0;
    m_done = '0;
    m_busy = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    if (m_done != '0) begin
      m_done = '0;
      m_busy = 1'b0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_own  = -1;
        m_cnt  = 0;
        m_busy = 1'b0;
      end else if (m_cnt == m_tgt) begin
        m_done        = '0;
        m_done[m_own] = 1'b1;
        m_own         = -1;
      end else begin
        m_cnt++;
      end
    end else if (req != '0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int c;
        c = (m_last + i) % NREQ;
        if (req[c]) begin
          m_own  = c;
          m_last = c;
          m_tgt  = int'(delay_in[c*WIDTH +: WIDTH]);
          m_cnt  = 0;
          m_busy = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    int eg;
    eg = (m_own >= 0) ? (1 << m_own) : 0;
    check_eq("grant", 32'(grant), eg);
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cnt_q", 32'(cnt_q), m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_cnt", 32'(cnt_q), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_delay(input int i, input int d);
    delay_in[i*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int gcnt;
    int dcnt;
    int maxc;
    int seen;
    int starts[$];
    int stamps[$];
    logic [NREQ-1:0] prev;

    model_reset();

    // 1: single request, D=3
    do_reset();
    set_delay(0, 3);
    req  = 4'b0001;
    gcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (grant == 4'b0001) gcnt++;
      if (done == 4'b0001) begin
        dcnt++;
        req = '0;
      end
    end
    check_eq("s1_grant_cycles", gcnt, 4);
    check_eq("s1_done_pulses", dcnt, 1);
    check_eq("s1_idle_busy", 32'(busy), 0);

    // 2: all request with D=0, held through done
    do_reset();
    for (int i = 0; i < NREQ; i++) set_delay(i, 0);
    req  = 4'b1111;
    prev = '0;
    starts.delete();
    stamps.delete();
    for (int i = 0; i < 40 && starts.size() < 5; i++) begin
      tick();
      if (grant != '0 && prev == '0) begin
        starts.push_back(idx_of(grant));
        stamps.push_back(i);
      end
      prev = grant;
    end
    check_eq("s2_nstarts", starts.size(), 5);
    if (starts.size() == 5) begin
      for (int k = 0; k < 5; k++) check_eq("s2_order", starts[k], k % NREQ);
      for (int k = 1; k < 5; k++) check_eq("s2_spacing", stamps[k] - stamps[k-1], 3);
    end
    req = '0;
    for (int i = 0; i < 5; i++) tick();

    // 3: maximum delay, no wrap
    do_reset();
    set_delay(1, 255);
    req  = 4'b0010;
    gcnt = 0;
    maxc = 0;
    dcnt = 0;
    for (int i = 0; i < 300 && dcnt == 0; i++) begin
      tick();
      if (grant == 4'b0010) gcnt++;
      if (int'(cnt_q) > maxc) maxc = int'(cnt_q);
      if (done == 4'b0010) begin
        dcnt++;
        req = '0;
      end
    end
    check_eq("s3_grant_cycles", gcnt, 256);
    check_eq("s3_peak", maxc, 255);
    check_eq("s3_done", dcnt, 1);
    for (int i = 0; i < 3; i++) tick();

    // 4: abort at cnt_q=5, pending requester takes over
    do_reset();
    set_delay(2, 10);
    set_delay(3, 2);
    req  = 4'b1100;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      tick();
      if (grant == 4'b0100 && cnt_q == 8'd5) seen = 1;
    end
    check_eq("s4_reached5", seen, 1);
    req[2] = 1'b0;
    tick();
    check_eq("s4_abort_grant", 32'(grant), 0);
    check_eq("s4_abort_done", 32'(done), 0);
    check_eq("s4_abort_cnt", 32'(cnt_q), 0);
    seen = 0;
    for (int i = 0; i < 5 && seen == 0; i++) begin
      tick();
      if (grant == 4'b1000) seen = 1;
    end
    check_eq("s4_next_owner", seen, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done[3]) req[3] = 1'b0;
    end

    // 5: async reset mid-run, then round-robin restarts at req[0]
    do_reset();
    set_delay(0, 10);
    req  = 4'b0001;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (cnt_q == 8'd4 && grant == 4'b0001) seen = 1;
    end
    check_eq("s5_reached4", seen, 1);
    req = 4'b1010;
    set_delay(1, 2);
    set_delay(3, 2);
    do_reset();
    prev = '0;
    for (int i = 0; i < 5 && prev == '0; i++) begin
      tick();
      prev = grant;
    end
    check_eq("s5_winner", 32'(prev), 32'(4'b0010));
    req = '0;
    for (int i = 0; i < 6; i++) tick();

    // 6: re-request after done goes to the back of the rotation
    do_reset();
    set_delay(1, 1);
    set_delay(3, 1);
    req  = 4'b1010;
    prev = '0;
    starts.delete();
    for (int i = 0; i < 30 && starts.size() < 3; i++) begin
      tick();
      if (grant != '0 && prev == '0) starts.push_back(idx_of(grant));
      prev = grant;
    end
    check_eq("s6_nstarts", starts.size(), 3);
    if (starts.size() == 3) begin
      check_eq("s6_first", starts[0], 1);
      check_eq("s6_second", starts[1], 3);
      check_eq("s6_third", starts[2], 1);
    end
    req = '0;
    for (int i = 0; i < 6; i++) tick();

    // Random traffic: delays churn every cycle, requests rise, hold, sometimes withdraw
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_delay(i, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
